// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_W = 32;
  localparam int OFFS_W = 2;

  // Misaligned, or word index beyond the array (upper bits never alias).
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
    logic [31:0] idx;
    idx      = {2'b00, addr[31:OFFS_W]};
    addr_err = (addr[OFFS_W-1:0] != '0) || (idx >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, async clear.
module dmem_array
  import pipe_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] rd_words [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;

    always_comb begin
      word_d = word_q;
      if (we && (waddr == AW'(gi))) begin
        word_d = wdata;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign rd_words[gi] = word_q;
  end

  assign rdata = rd_words[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the MEM-stage load/store interface with configurable wait states.
// Optional error counter output enabled by DMEM_ERR_COUNT_EN.
module dmem_responder
  import pipe_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 2,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_ERR_COUNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              acc_err;
  logic [AW-1:0]     acc_idx;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign acc_err = addr_err(addr_q, 32'(DEPTH));
  assign acc_idx = addr_q[OFFS_W +: AW];

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .resetn (resetn),
    .we     (mem_we),
    .waddr  (acc_idx),
    .wdata  (wdata_q),
    .raddr  (acc_idx),
    .rdata  (mem_rdata)
  );

  // Every request passes through WAIT for WAIT_CYC+1 cycles, so the commit always
  // works from the latched request and latency is WAIT_CYC+1 even when WAIT_CYC=0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(WAIT_CYC);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          err_d   = acc_err;
          mem_we  = we_q && !acc_err;
          rdata_d = (!we_q && !acc_err) ? mem_rdata : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef DMEM_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == RESP) && rsp_ready && err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: instance A uses WAIT_CYC=2, instance B uses WAIT_CYC=0.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
`ifdef DMEM_ERR_COUNT_EN
  logic [15:0] a_err_count, b_err_count;
`endif

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH(64), .WAIT_CYC(2), .CNT_W(4)) dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
`ifdef DMEM_ERR_COUNT_EN
    ,
    .err_count (a_err_count)
`endif
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYC(0), .CNT_W(4)) dut_b (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
`ifdef DMEM_ERR_COUNT_EN
    ,
    .err_count (b_err_count)
`endif
  );

  logic        use_b = 1'b0;
  logic        cur_ready, cur_valid, cur_err;
  logic [31:0] cur_rdata;
  assign cur_ready = use_b ? b_req_ready : a_req_ready;
  assign cur_valid = use_b ? b_rsp_valid : a_rsp_valid;
  assign cur_err   = use_b ? b_rsp_err   : a_rsp_err;
  assign cur_rdata = use_b ? b_rsp_rdata : a_rsp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response; hold = cycles rsp_ready stays low once rsp_valid is up.
  task automatic txn(input logic sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int lat;
    int exp_lat;
    logic [31:0] rd0;
    use_b   = sel;
    exp_lat = sel ? 1 : 3;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(cur_ready), 32'd1);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    if (sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    chk({tag, " req_ready busy"}, 32'(cur_ready), 32'd0);
    lat = 0;
    while (!cur_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, cur_rdata, exp_rd);
    chk({tag, " err"}, 32'(cur_err), 32'(exp_err));
    rd0 = cur_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(cur_valid), 32'd1);
      chk({tag, " hold rdata"}, cur_rdata, rd0);
      chk({tag, " hold req_ready"}, 32'(cur_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " post valid"}, 32'(cur_valid), 32'd0);
    chk({tag, " post req_ready"}, 32'(cur_ready), 32'd1);
    chk({tag, " post rdata"}, cur_rdata, 32'd0);
    chk({tag, " post err"}, 32'(cur_err), 32'd0);
    $display("txn %-14s dut=%s we=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0d",
             tag, sel ? "B" : "A", we, addr, wd, lat, rd0, exp_err);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset req_ready", 32'(a_req_ready), 32'd1);
    chk("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("reset rdata", a_rsp_rdata, 32'd0);
    chk("reset err", 32'(a_rsp_err), 32'd0);
`ifdef DMEM_ERR_COUNT_EN
    chk("reset err_count", 32'(a_err_count), 32'd0);
`endif
    resetn = 1'b1;

    txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, "store_10");
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0, "load_10");
    txn(1'b0, 1'b0, 32'h0000_0013, 32'h0,         0, 32'h0,         1'b1, "load_13_mis");
    txn(1'b0, 1'b1, 32'h0000_0016, 32'hCAFE_F00D, 0, 32'h0,         1'b1, "store_16_mis");
    txn(1'b0, 1'b0, 32'h0000_0014, 32'h0,         0, 32'h0,         1'b0, "load_14");
    txn(1'b0, 1'b0, 32'h0000_0100, 32'h0,         0, 32'h0,         1'b1, "load_100_oor");
    txn(1'b0, 1'b1, 32'h0000_00FC, 32'h55AA_33CC, 0, 32'h0,         1'b0, "store_fc");
    txn(1'b0, 1'b0, 32'h0000_00FC, 32'h0,         0, 32'h55AA_33CC, 1'b0, "load_fc");
    txn(1'b0, 1'b0, 32'h8000_0010, 32'h0,         0, 32'h0,         1'b1, "load_hi_alias");
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF, 1'b0, "load_10_bp");
`ifdef DMEM_ERR_COUNT_EN
    chk("err_count after 4 errors", 32'(a_err_count), 32'd4);
`endif

    txn(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 0, 32'h0,         1'b0, "b_store_40");
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0,         0, 32'h0BAD_F00D, 1'b0, "b_load_40");
    txn(1'b1, 1'b0, 32'h0000_0042, 32'h0,         2, 32'h0,         1'b1, "b_load_42_mis");

    // Reset during WAIT of a store: the store must be lost.
    use_b = 1'b0;
    @(negedge clk);
    req_we      = 1'b1;
    req_addr    = 32'h0000_0020;
    req_wdata   = 32'h1234_5678;
    a_req_valid = 1'b1;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #2;
    chk("midreset req_ready", 32'(a_req_ready), 32'd1);
    chk("midreset rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("midreset rdata", a_rsp_rdata, 32'd0);
    chk("midreset err", 32'(a_rsp_err), 32'd0);
`ifdef DMEM_ERR_COUNT_EN
    chk("midreset err_count", 32'(a_err_count), 32'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    $display("txn %-14s dut=A reset pulsed during WAIT of store to 00000020", "reset_wait");
    txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 0, 32'h0, 1'b0, "load_20_lost");
    txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, 1'b0, "load_10_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
